// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the pipeline hazard logic.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W        = 5;
    localparam int unsigned PHYS_ADDR_W       = REG_ADDR_W + 1;
    localparam int unsigned MULDIV_CNT_W      = 4;
    localparam int unsigned MULDIV_CYCLES_DEF = 8;

    // Winning hazard source for the current cycle, highest priority first.
    typedef enum logic [1:0] {
        HZ_NONE  = 2'd0,
        HZ_MEM   = 2'd1,
        HZ_FLUSH = 2'd2,
        HZ_STALL = 2'd3
    } hz_cause_e;

endpackage

// File: rtl/hazard_unit_muldiv_tracker.sv
// Tracks the in-flight multiply/divide: loads on issue, counts down to idle.
module muldiv_tracker
    import cpu_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = MULDIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic issue_i,
    output logic busy_o
);

    logic [MULDIV_CNT_W-1:0] cnt_q;
    logic [MULDIV_CNT_W-1:0] cnt_d;

    // The unit runs independently of the pipeline, so no stall freezes the count.
    always_comb begin
        cnt_d = cnt_q;
        if (issue_i) begin
            cnt_d = MULDIV_CNT_W'(MULDIV_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - MULDIV_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_unit.sv
// Decode-side hazard detector: load-use, muldiv occupancy and dcache stalls,
// producing stall/bubble/flush controls plus a saturating stall counter.
module hazard_unit
    import cpu_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = PHYS_ADDR_W - 1,
    parameter int unsigned MULDIV_CYCLES  = MULDIV_CYCLES_DEF,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid,
    input  logic                  dec_rs_enable,
    input  logic [REG_ADDR_WIDTH:0] dec_prs_addr,
    input  logic                  dec_rt_enable,
    input  logic [REG_ADDR_WIDTH:0] dec_prt_addr,
    input  logic                  dec_muldiv,
    input  logic                  dec_hilo_read,
    input  logic                  exec_valid,
    input  logic                  exec_wb_reg,
    input  logic                  exec_alu_en,
    input  logic [REG_ADDR_WIDTH:0] exec_write_addr,
    input  logic                  exec_branch_taken,
    input  logic                  mem_stall,
    output logic                  pc_stall,
    output logic                  dec_stall,
    output logic                  exec_stall,
    output logic                  exec_bubble,
    output logic                  fetch_flush,
    output logic                  dec_flush,
    output logic                  muldiv_busy,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    logic            load_use;
    logic            muldiv_hz;
    logic            issue;
    hz_cause_e       cause;
    logic [CNT_WIDTH-1:0] stall_count_q;
    logic [CNT_WIDTH-1:0] stall_count_d;

    // A pending load only hazards when its consumer reads the same physical register.
    always_comb begin
        load_use  = dec_valid & exec_valid & exec_wb_reg & ~exec_alu_en &
                    ((dec_rs_enable & (dec_prs_addr == exec_write_addr)) |
                     (dec_rt_enable & (dec_prt_addr == exec_write_addr)));
        muldiv_hz = dec_valid & (dec_hilo_read | dec_muldiv) & muldiv_busy;
    end

    always_comb begin
        cause = HZ_NONE;
        if (mem_stall) begin
            cause = HZ_MEM;
        end else if (exec_branch_taken) begin
            cause = HZ_FLUSH;
        end else if (load_use | muldiv_hz) begin
            cause = HZ_STALL;
        end
    end

    always_comb begin
        pc_stall    = 1'b0;
        dec_stall   = 1'b0;
        exec_stall  = 1'b0;
        exec_bubble = 1'b0;
        fetch_flush = 1'b0;
        dec_flush   = 1'b0;
        unique case (cause)
            HZ_MEM: begin
                pc_stall   = 1'b1;
                dec_stall  = 1'b1;
                exec_stall = 1'b1;
            end
            HZ_FLUSH: begin
                fetch_flush = 1'b1;
                dec_flush   = 1'b1;
            end
            HZ_STALL: begin
                pc_stall    = 1'b1;
                dec_stall   = 1'b1;
                exec_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    assign issue = dec_valid & dec_muldiv & (cause == HZ_NONE);

    muldiv_tracker #(
        .MULDIV_CYCLES (MULDIV_CYCLES)
    ) u_muldiv_tracker (
        .clk     (clk),
        .rst     (rst),
        .issue_i (issue),
        .busy_o  (muldiv_busy)
    );

    always_comb begin
        stall_count_d = stall_count_q;
        if (pc_stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus random traffic
// against a cycle-level behavioural model.
module tb_hazard_unit;
    import cpu_pkg::*;

    localparam int unsigned AW  = PHYS_ADDR_W;
    localparam int unsigned MC  = 8;
    localparam int unsigned CW  = 32;
    localparam int unsigned SCW = 4;

    typedef struct packed {
        logic          v;
        logic          rse;
        logic [AW-1:0] rs;
        logic          rte;
        logic [AW-1:0] rt;
        logic          md;
        logic          hl;
        logic          ev;
        logic          ewb;
        logic          ealu;
        logic [AW-1:0] wa;
        logic          br;
        logic          ms;
    } stim_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          dec_valid, dec_rs_enable, dec_rt_enable, dec_muldiv, dec_hilo_read;
    logic [AW-1:0] dec_prs_addr, dec_prt_addr, exec_write_addr;
    logic          exec_valid, exec_wb_reg, exec_alu_en, exec_branch_taken, mem_stall;
    logic          pc_stall, dec_stall, exec_stall, exec_bubble, fetch_flush, dec_flush, muldiv_busy;
    logic [CW-1:0] stall_count;
    logic          s_pc, s_dec, s_ex, s_bub, s_ff, s_df, s_busy;
    logic [SCW-1:0] s_count;

    hazard_unit #(.REG_ADDR_WIDTH(REG_ADDR_W), .MULDIV_CYCLES(MC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_rs_enable(dec_rs_enable), .dec_prs_addr(dec_prs_addr),
        .dec_rt_enable(dec_rt_enable), .dec_prt_addr(dec_prt_addr),
        .dec_muldiv(dec_muldiv), .dec_hilo_read(dec_hilo_read),
        .exec_valid(exec_valid), .exec_wb_reg(exec_wb_reg), .exec_alu_en(exec_alu_en),
        .exec_write_addr(exec_write_addr), .exec_branch_taken(exec_branch_taken),
        .mem_stall(mem_stall),
        .pc_stall(pc_stall), .dec_stall(dec_stall), .exec_stall(exec_stall),
        .exec_bubble(exec_bubble), .fetch_flush(fetch_flush), .dec_flush(dec_flush),
        .muldiv_busy(muldiv_busy), .stall_count(stall_count)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    hazard_unit #(.REG_ADDR_WIDTH(REG_ADDR_W), .MULDIV_CYCLES(MC), .CNT_WIDTH(SCW)) dut_sat (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_rs_enable(dec_rs_enable), .dec_prs_addr(dec_prs_addr),
        .dec_rt_enable(dec_rt_enable), .dec_prt_addr(dec_prt_addr),
        .dec_muldiv(dec_muldiv), .dec_hilo_read(dec_hilo_read),
        .exec_valid(exec_valid), .exec_wb_reg(exec_wb_reg), .exec_alu_en(exec_alu_en),
        .exec_write_addr(exec_write_addr), .exec_branch_taken(exec_branch_taken),
        .mem_stall(mem_stall),
        .pc_stall(s_pc), .dec_stall(s_dec), .exec_stall(s_ex),
        .exec_bubble(s_bub), .fetch_flush(s_ff), .dec_flush(s_df),
        .muldiv_busy(s_busy), .stall_count(s_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: cycles left on the muldiv unit, stall tallies.
    int              m_left;
    longint unsigned m_stalls;
    longint unsigned m_sat;
    localparam longint unsigned MAX_MAIN = 64'hFFFF_FFFF;
    localparam longint unsigned MAX_SAT  = 64'd15;

    // Values sampled from the DUT during the last step, for directed checks.
    logic o_pc, o_dec, o_ex, o_bub, o_ff, o_df, o_busy;
    logic [CW-1:0] o_cnt;

    stim_t s;

    task automatic step(input logic r);
        bit lu, mh, stall_req, issue;
        bit e_pc, e_dec, e_ex, e_bub, e_ff, e_df;
        @(negedge clk);
        rst = r;
        dec_valid = s.v; dec_rs_enable = s.rse; dec_prs_addr = s.rs;
        dec_rt_enable = s.rte; dec_prt_addr = s.rt;
        dec_muldiv = s.md; dec_hilo_read = s.hl;
        exec_valid = s.ev; exec_wb_reg = s.ewb; exec_alu_en = s.ealu;
        exec_write_addr = s.wa; exec_branch_taken = s.br; mem_stall = s.ms;

        lu = s.v && s.ev && s.ewb && !s.ealu &&
             ((s.rse && s.rs == s.wa) || (s.rte && s.rt == s.wa));
        mh = s.v && (s.hl || s.md) && (m_left > 0);
        stall_req = lu || mh;
        e_pc = s.ms || (!s.br && stall_req);
        e_dec = e_pc;
        e_ex = s.ms;
        e_bub = !s.ms && !s.br && stall_req;
        e_ff = !s.ms && s.br;
        e_df = e_ff;
        issue = s.v && s.md && !s.ms && !s.br && !stall_req;

        #2;
        o_pc = pc_stall; o_dec = dec_stall; o_ex = exec_stall; o_bub = exec_bubble;
        o_ff = fetch_flush; o_df = dec_flush; o_busy = muldiv_busy; o_cnt = stall_count;
        check("pc_stall",    64'(pc_stall),    64'(e_pc));
        check("dec_stall",   64'(dec_stall),   64'(e_dec));
        check("exec_stall",  64'(exec_stall),  64'(e_ex));
        check("exec_bubble", 64'(exec_bubble), 64'(e_bub));
        check("fetch_flush", 64'(fetch_flush), 64'(e_ff));
        check("dec_flush",   64'(dec_flush),   64'(e_df));
        check("muldiv_busy", 64'(muldiv_busy), 64'(m_left > 0));
        check("stall_count", 64'(stall_count), m_stalls);
        check("sat_count",   64'(s_count),     m_sat);

        @(posedge clk);
        if (r) begin
            m_left = 0; m_stalls = 0; m_sat = 0;
        end else begin
            if (issue) m_left = int'(MC);
            else if (m_left > 0) m_left = m_left - 1;
            if (e_pc) begin
                if (m_stalls < MAX_MAIN) m_stalls = m_stalls + 1;
                if (m_sat < MAX_SAT) m_sat = m_sat + 1;
            end
        end
    endtask

    task automatic idle_reset();
        s = '0;
        step(1'b1);
        step(1'b1);
    endtask

    int busy_seen;
    int stall_seen;

    initial begin
        m_left = 0; m_stalls = 0; m_sat = 0;
        s = '0;
        rst = 1'b1;
        dec_valid = 0; dec_rs_enable = 0; dec_prs_addr = '0; dec_rt_enable = 0;
        dec_prt_addr = '0; dec_muldiv = 0; dec_hilo_read = 0; exec_valid = 0;
        exec_wb_reg = 0; exec_alu_en = 0; exec_write_addr = '0;
        exec_branch_taken = 0; mem_stall = 0;

        // Reset state with idle inputs.
        idle_reset();
        s = '0;
        step(1'b0);
        check("rst_outputs", 64'({o_pc, o_dec, o_ex, o_bub, o_ff, o_df, o_busy}), 64'd0);
        check("rst_count", 64'(o_cnt), 64'd0);

        // Load-use on rs: one stall, then the bubble clears it.
        s = '0; s.v = 1; s.rse = 1; s.rs = AW'(5); s.ev = 1; s.ewb = 1; s.ealu = 0; s.wa = AW'(5);
        step(1'b0);
        check("lu_stall", 64'({o_pc, o_dec, o_bub, o_ex}), 64'b1110);
        s.ev = 0;
        step(1'b0);
        check("lu_release", 64'({o_pc, o_dec, o_bub}), 64'd0);
        check("lu_count", 64'(o_cnt), 64'd1);

        // ALU producer is forwarded, no stall.
        s = '0; s.v = 1; s.rse = 1; s.rs = AW'(5); s.ev = 1; s.ewb = 1; s.ealu = 1; s.wa = AW'(5);
        step(1'b0);
        check("alu_nostall", 64'({o_pc, o_dec, o_bub}), 64'd0);

        // div issues, mflo waits for MC cycles then proceeds.
        s = '0; s.v = 1; s.md = 1;
        step(1'b0);
        check("div_issue_nostall", 64'(o_pc), 64'd0);
        s = '0; s.v = 1; s.hl = 1;
        busy_seen = 0; stall_seen = 0;
        for (int i = 0; i < int'(MC); i++) begin
            step(1'b0);
            busy_seen += int'(o_busy);
            stall_seen += int'(o_pc);
        end
        check("mflo_busy_cycles", 64'(busy_seen), 64'(MC));
        check("mflo_stall_cycles", 64'(stall_seen), 64'(MC));
        step(1'b0);
        check("mflo_proceeds", 64'({o_pc, o_busy}), 64'd0);

        // Branch flush beats load-use and blocks muldiv issue.
        s = '0; s.v = 1; s.md = 1; s.rse = 1; s.rs = AW'(3); s.ev = 1; s.ewb = 1; s.wa = AW'(3); s.br = 1;
        step(1'b0);
        check("flush_ctrl", 64'({o_ff, o_df, o_pc, o_dec, o_bub}), 64'b11000);
        s = '0;
        step(1'b0);
        check("flush_no_issue", 64'(o_busy), 64'd0);

        // mem_stall over a pending load-use; muldiv counter keeps running (5 -> 4).
        s = '0; s.v = 1; s.md = 1;
        step(1'b0);
        s = '0;
        for (int i = 0; i < 3; i++) step(1'b0);
        s = '0; s.v = 1; s.rt = AW'(9); s.rte = 1; s.ev = 1; s.ewb = 1; s.wa = AW'(9); s.ms = 1;
        step(1'b0);
        check("mem_ctrl", 64'({o_pc, o_dec, o_ex, o_bub}), 64'b1110);
        s = '0;
        busy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0);
            busy_seen += int'(o_busy);
        end
        check("mem_counter_runs", 64'(busy_seen), 64'd4);

        // Reset mid-muldiv with the counter at 6.
        s = '0; s.v = 1; s.md = 1;
        step(1'b0);
        s = '0;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        check("rst_mid_busy", 64'(o_busy), 64'd0);
        check("rst_mid_count", 64'(o_cnt), 64'd0);

        // Saturation on the narrow counter.
        s = '0; s.ms = 1;
        for (int i = 0; i < 20; i++) step(1'b0);
        check("sat_limit", 64'(s_count), 64'd15);
        s = '0;
        step(1'b0);

        // Random traffic over a small register window to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            s.v    = 1'($urandom_range(0, 3) != 0);
            s.rse  = 1'($urandom_range(0, 1));
            s.rs   = AW'($urandom_range(0, 3));
            s.rte  = 1'($urandom_range(0, 1));
            s.rt   = AW'($urandom_range(0, 3));
            s.md   = 1'($urandom_range(0, 3) == 0);
            s.hl   = 1'($urandom_range(0, 3) == 0);
            s.ev   = 1'($urandom_range(0, 3) != 0);
            s.ewb  = 1'($urandom_range(0, 3) != 0);
            s.ealu = 1'($urandom_range(0, 1));
            s.wa   = AW'($urandom_range(0, 3));
            s.br   = 1'($urandom_range(0, 7) == 0);
            s.ms   = 1'($urandom_range(0, 7) == 0);
            step(1'($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and stall controller for the in-order MIPS core. It sits beside the decode stage, directly upstream of the forwarding unit. It detects the hazards that forwarding cannot resolve: load-use, multiply/divide occupancy and data-cache stalls. From these it produces the stall, bubble and flush controls for fetch, decode and execute. It also tracks the in-flight multiply/divide operation and keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, architectural register address width; physical addresses are REG_ADDR_WIDTH+1 bits.
- MULDIV_CYCLES, 8, latency of the multiply/divide unit in cycles; legal range 1..15.
- CNT_WIDTH, 32, width of the stall performance counter.

Ports (clock is `clk`, reset is `rst`; one clock, synchronous active-high reset):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- dec_valid  in  1  decode stage holds a live instruction.
- dec_rs_enable  in  1  decode instruction reads rs.
- dec_prs_addr  in  REG_ADDR_WIDTH+1  physical rs address.
- dec_rt_enable  in  1  decode instruction reads rt.
- dec_prt_addr  in  REG_ADDR_WIDTH+1  physical rt address.
- dec_muldiv  in  1  decode instruction is mult/multu/div/divu.
- dec_hilo_read  in  1  decode instruction is mfhi/mflo.
- exec_valid  in  1  execute stage holds a live instruction.
- exec_wb_reg  in  1  execute instruction writes a register.
- exec_alu_en  in  1  execute result comes from the ALU; 0 means a load whose data is not ready yet.
- exec_write_addr  in  REG_ADDR_WIDTH+1  execute destination.
- exec_branch_taken  in  1  execute resolved a taken branch or jump.
- mem_stall  in  1  data cache miss pending.
- pc_stall  out  1  hold PC.
- dec_stall  out  1  hold the fetch/decode pipeline register.
- exec_stall  out  1  hold the decode/execute pipeline register.
- exec_bubble  out  1  load a NOP into the decode/execute register.
- fetch_flush  out  1  kill the instruction in fetch.
- dec_flush  out  1  kill the instruction in decode.
- muldiv_busy  out  1  multiply/divide in flight.
- stall_count  out  CNT_WIDTH  saturating count of stalled cycles.

## Operation
- load_use = dec_valid & exec_valid & exec_wb_reg & ~exec_alu_en & ((dec_rs_enable & dec_prs_addr==exec_write_addr) | (dec_rt_enable & dec_prt_addr==exec_write_addr)).
- muldiv_hz = dec_valid & (dec_hilo_read | dec_muldiv) & muldiv_busy.
- Priority, highest first:
  - mem_stall: pc_stall = dec_stall = exec_stall = 1; all other outputs 0. The whole front end freezes.
  - exec_branch_taken: fetch_flush = dec_flush = 1; no stall. A flush overrides load_use and muldiv_hz, because the hazarding instruction is killed.
  - load_use or muldiv_hz: pc_stall = dec_stall = exec_bubble = 1.
  - Otherwise all outputs are 0.
- Issue = dec_valid & dec_muldiv & no mem_stall/flush/load_use/muldiv_hz in the same cycle.
- Muldiv counter: 4-bit register.
  - Issue loads it with MULDIV_CYCLES.
  - Otherwise it decrements when nonzero. It decrements every cycle, including during mem_stall, because the unit runs independently.
  - muldiv_busy = (counter != 0).
- An issued muldiv is never cancelled by a later flush.
- stall_count increments on every cycle in which pc_stall=1 and saturates at all-ones.
- Address 0 gets no special treatment; writes to $zero are suppressed upstream via exec_wb_reg.

## Timing
- All stall, bubble and flush outputs are combinational from the current inputs and registered state, with zero-cycle latency. Only the counter and stall_count are registered.
- A load-use stall lasts exactly one cycle. Next cycle the load sits in memory access, exec_valid carries the bubble, and forwarding supplies the data.
- Muldiv issued in cycle t gives muldiv_busy=1 from t+1 through t+MULDIV_CYCLES, and 0 at t+MULDIV_CYCLES+1. An mfhi/mflo in decode stalls until that cycle.
- Back-to-back muldiv: the second one stalls while busy and issues in the first cycle where busy=0.
- Reset values: counter=0, stall_count=0. With reset inputs idle, every output reads 0.
- rst asserted mid-operation clears the counter and stall_count on the next edge, abandoning any in-flight muldiv tracking.

## Structure
- Shared package `cpu_pkg` holds the muldiv counter width, the MULDIV_CYCLES default and the physical register address width constant.
- One sub-module, `muldiv_tracker`. It contains the load/decrement counter and the busy output, and takes issue as input.
- The remaining hazard equations, the priority logic and the performance counter stay in `hazard_unit`.

## Test plan
- Load-use: exec load (exec_alu_en=0) to p5, decode reads rs=p5. Required: one cycle of pc_stall=dec_stall=exec_bubble=1, then none. stall_count goes from 0 to 1.
- ALU producer: same addresses with exec_alu_en=1. Required: no stall, because forwarding covers it.
- Muldiv, MULDIV_CYCLES=8: div issued at cycle 10, mflo in decode from cycle 11. Required: busy during cycles 11-18, stalls during 11-18, mflo proceeds at 19.
- Flush vs hazard: load_use and exec_branch_taken asserted together. Required: fetch_flush=dec_flush=1, no stall, no bubble, no muldiv issue.
- mem_stall with a pending load_use. Required: pc_stall=dec_stall=exec_stall=1 and exec_bubble=0. The muldiv counter still decrements (from 5 to 4).
- Reset mid-muldiv with counter at 6: rst pulsed for one cycle. Required: busy=0 and stall_count=0 the following cycle; stall_count saturates at 0xFFFFFFFF when preloaded near the limit.
